// File: rtl/gp_regarb.sv
// Arbitrates single AXI3 transactions from PS7 GP0/GP1 onto a shared 4-word register bank
// (LED, SCRATCH, COUNT, GRANTS) with round-robin priority and one transaction in flight.
module gp_regarb #(
    parameter logic [7:0]  LED_RST     = 8'h00,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        i_clk0,
    input  logic        i_rst,
    input  logic [11:0] i_M_AXI_GP0_AWID,
    input  logic [31:0] i_M_AXI_GP0_AWADDR,
    input  logic [3:0]  i_M_AXI_GP0_AWLEN,
    input  logic        i_M_AXI_GP0_AWVALID,
    output logic        o_M_AXI_GP0_AWREADY,
    input  logic [31:0] i_M_AXI_GP0_WDATA,
    input  logic [3:0]  i_M_AXI_GP0_WSTRB,
    input  logic        i_M_AXI_GP0_WVALID,
    output logic        o_M_AXI_GP0_WREADY,
    output logic [11:0] o_M_AXI_GP0_BID,
    output logic [1:0]  o_M_AXI_GP0_BRESP,
    output logic        o_M_AXI_GP0_BVALID,
    input  logic        i_M_AXI_GP0_BREADY,
    input  logic [11:0] i_M_AXI_GP0_ARID,
    input  logic [31:0] i_M_AXI_GP0_ARADDR,
    input  logic [3:0]  i_M_AXI_GP0_ARLEN,
    input  logic        i_M_AXI_GP0_ARVALID,
    output logic        o_M_AXI_GP0_ARREADY,
    output logic [11:0] o_M_AXI_GP0_RID,
    output logic [31:0] o_M_AXI_GP0_RDATA,
    output logic [1:0]  o_M_AXI_GP0_RRESP,
    output logic        o_M_AXI_GP0_RLAST,
    output logic        o_M_AXI_GP0_RVALID,
    input  logic        i_M_AXI_GP0_RREADY,
    input  logic [11:0] i_M_AXI_GP1_AWID,
    input  logic [31:0] i_M_AXI_GP1_AWADDR,
    input  logic [3:0]  i_M_AXI_GP1_AWLEN,
    input  logic        i_M_AXI_GP1_AWVALID,
    output logic        o_M_AXI_GP1_AWREADY,
    input  logic [31:0] i_M_AXI_GP1_WDATA,
    input  logic [3:0]  i_M_AXI_GP1_WSTRB,
    input  logic        i_M_AXI_GP1_WVALID,
    output logic        o_M_AXI_GP1_WREADY,
    output logic [11:0] o_M_AXI_GP1_BID,
    output logic [1:0]  o_M_AXI_GP1_BRESP,
    output logic        o_M_AXI_GP1_BVALID,
    input  logic        i_M_AXI_GP1_BREADY,
    input  logic [11:0] i_M_AXI_GP1_ARID,
    input  logic [31:0] i_M_AXI_GP1_ARADDR,
    input  logic [3:0]  i_M_AXI_GP1_ARLEN,
    input  logic        i_M_AXI_GP1_ARVALID,
    output logic        o_M_AXI_GP1_ARREADY,
    output logic [11:0] o_M_AXI_GP1_RID,
    output logic [31:0] o_M_AXI_GP1_RDATA,
    output logic [1:0]  o_M_AXI_GP1_RRESP,
    output logic        o_M_AXI_GP1_RLAST,
    output logic        o_M_AXI_GP1_RVALID,
    input  logic        i_M_AXI_GP1_RREADY,
    output logic [7:0]  o_led
);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_ptr;
    logic        r_port;
    logic [11:0] r_id;
    logic [3:0]  r_cnt;
    logic [1:0]  r_resp;
    logic        r_widx;
    logic [31:0] r_rdata;
    logic [7:0]  r_led;
    logic [31:0] r_scratch;
    logic [31:0] r_count;
    logic [15:0] r_gnt0, r_gnt1;

    logic [3:0]  w_req;
    logic [1:0]  w_idx, w_win;
    logic        w_win_vld, w_grant;
    logic [11:0] w_id;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [1:0]  w_resp;
    logic [31:0] w_rval;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_whs, w_rhs, w_bhs;
    logic        w_unused_addr;

    // Ring order: 0=GP0-W, 1=GP0-R, 2=GP1-W, 3=GP1-R
    assign w_req = {i_M_AXI_GP1_ARVALID, i_M_AXI_GP1_AWVALID,
                    i_M_AXI_GP0_ARVALID, i_M_AXI_GP0_AWVALID};

    always_comb begin
        w_win_vld = 1'b0;
        w_win     = 2'd0;
        w_idx     = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(3 - i);
            if (w_req[w_idx]) begin
                w_win_vld = 1'b1;
                w_win     = w_idx;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && !i_rst && w_win_vld;

    always_comb begin
        case (w_win)
            2'd0:    begin w_id = i_M_AXI_GP0_AWID; w_addr = i_M_AXI_GP0_AWADDR; w_len = i_M_AXI_GP0_AWLEN; end
            2'd1:    begin w_id = i_M_AXI_GP0_ARID; w_addr = i_M_AXI_GP0_ARADDR; w_len = i_M_AXI_GP0_ARLEN; end
            2'd2:    begin w_id = i_M_AXI_GP1_AWID; w_addr = i_M_AXI_GP1_AWADDR; w_len = i_M_AXI_GP1_AWLEN; end
            default: begin w_id = i_M_AXI_GP1_ARID; w_addr = i_M_AXI_GP1_ARADDR; w_len = i_M_AXI_GP1_ARLEN; end
        endcase
    end

    assign w_unused_addr = ^w_addr[1:0];

    always_comb begin
        if (|w_addr[31:4])
            w_resp = RESP_DECERR;
        else if ((w_len != 4'd0) || (!w_win[0] && w_addr[3]))
            w_resp = RESP_SLVERR;
        else
            w_resp = RESP_OKAY;
    end

    // GRANTS readback already includes the grant being issued this cycle
    always_comb begin
        case (w_addr[3:2])
            2'd0:    w_rval = {24'h0, r_led};
            2'd1:    w_rval = r_scratch;
            2'd2:    w_rval = r_count;
            default: w_rval = {r_gnt1 + 16'(w_win[1]), r_gnt0 + 16'(!w_win[1])};
        endcase
    end

    assign w_wdata = r_port ? i_M_AXI_GP1_WDATA : i_M_AXI_GP0_WDATA;
    assign w_wstrb = r_port ? i_M_AXI_GP1_WSTRB : i_M_AXI_GP0_WSTRB;
    assign w_whs   = (r_state == S_WDATA) && (r_port ? i_M_AXI_GP1_WVALID : i_M_AXI_GP0_WVALID);
    assign w_rhs   = (r_state == S_RDATA) && (r_port ? i_M_AXI_GP1_RREADY : i_M_AXI_GP0_RREADY);
    assign w_bhs   = (r_state == S_WRESP) && (r_port ? i_M_AXI_GP1_BREADY : i_M_AXI_GP0_BREADY);

    always_ff @(posedge i_clk0) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = w_win[0] ? S_RDATA : S_WDATA;
            S_WDATA: if (w_whs && (r_cnt == 4'd0)) w_state_nxt = S_WRESP;
            S_WRESP: if (w_bhs) w_state_nxt = S_IDLE;
            S_RDATA: if (w_rhs && (r_cnt == 4'd0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) begin
            r_ptr     <= 2'd0;
            r_port    <= 1'b0;
            r_id      <= 12'h0;
            r_cnt     <= 4'd0;
            r_resp    <= RESP_OKAY;
            r_widx    <= 1'b0;
            r_rdata   <= 32'h0;
            r_led     <= LED_RST;
            r_scratch <= SCRATCH_RST;
            r_count   <= 32'h0;
            r_gnt0    <= 16'h0;
            r_gnt1    <= 16'h0;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_grant) begin
                r_ptr   <= w_win + 2'd1;
                r_port  <= w_win[1];
                r_id    <= w_id;
                r_cnt   <= w_len;
                r_resp  <= w_resp;
                r_widx  <= w_addr[2];
                r_rdata <= (w_resp == RESP_OKAY) ? w_rval : 32'h0;
                if (w_win[1])
                    r_gnt1 <= r_gnt1 + 16'd1;
                else
                    r_gnt0 <= r_gnt0 + 16'd1;
            end else if ((w_whs || w_rhs) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Only the final beat of a clean single-beat write touches the bank
            if (w_whs && (r_cnt == 4'd0) && (r_resp == RESP_OKAY)) begin
                if (!r_widx) begin
                    if (w_wstrb[0]) r_led <= w_wdata[7:0];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (w_wstrb[b]) r_scratch[8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        o_M_AXI_GP0_AWREADY = 1'b0;  o_M_AXI_GP1_AWREADY = 1'b0;
        o_M_AXI_GP0_ARREADY = 1'b0;  o_M_AXI_GP1_ARREADY = 1'b0;
        o_M_AXI_GP0_WREADY  = 1'b0;  o_M_AXI_GP1_WREADY  = 1'b0;
        o_M_AXI_GP0_BVALID  = 1'b0;  o_M_AXI_GP1_BVALID  = 1'b0;
        o_M_AXI_GP0_BID     = 12'h0; o_M_AXI_GP1_BID     = 12'h0;
        o_M_AXI_GP0_BRESP   = 2'b00; o_M_AXI_GP1_BRESP   = 2'b00;
        o_M_AXI_GP0_RVALID  = 1'b0;  o_M_AXI_GP1_RVALID  = 1'b0;
        o_M_AXI_GP0_RID     = 12'h0; o_M_AXI_GP1_RID     = 12'h0;
        o_M_AXI_GP0_RDATA   = 32'h0; o_M_AXI_GP1_RDATA   = 32'h0;
        o_M_AXI_GP0_RRESP   = 2'b00; o_M_AXI_GP1_RRESP   = 2'b00;
        o_M_AXI_GP0_RLAST   = 1'b0;  o_M_AXI_GP1_RLAST   = 1'b0;
        o_M_AXI_GP0_AWREADY = w_grant && (w_win == 2'd0);
        o_M_AXI_GP0_ARREADY = w_grant && (w_win == 2'd1);
        o_M_AXI_GP1_AWREADY = w_grant && (w_win == 2'd2);
        o_M_AXI_GP1_ARREADY = w_grant && (w_win == 2'd3);
        if (!i_rst) begin
            case (r_state)
                S_WDATA: begin
                    if (r_port) o_M_AXI_GP1_WREADY = 1'b1;
                    else        o_M_AXI_GP0_WREADY = 1'b1;
                end
                S_WRESP: begin
                    if (r_port) begin
                        o_M_AXI_GP1_BVALID = 1'b1;
                        o_M_AXI_GP1_BID    = r_id;
                        o_M_AXI_GP1_BRESP  = r_resp;
                    end else begin
                        o_M_AXI_GP0_BVALID = 1'b1;
                        o_M_AXI_GP0_BID    = r_id;
                        o_M_AXI_GP0_BRESP  = r_resp;
                    end
                end
                S_RDATA: begin
                    if (r_port) begin
                        o_M_AXI_GP1_RVALID = 1'b1;
                        o_M_AXI_GP1_RID    = r_id;
                        o_M_AXI_GP1_RDATA  = r_rdata;
                        o_M_AXI_GP1_RRESP  = r_resp;
                        o_M_AXI_GP1_RLAST  = (r_cnt == 4'd0);
                    end else begin
                        o_M_AXI_GP0_RVALID = 1'b1;
                        o_M_AXI_GP0_RID    = r_id;
                        o_M_AXI_GP0_RDATA  = r_rdata;
                        o_M_AXI_GP0_RRESP  = r_resp;
                        o_M_AXI_GP0_RLAST  = (r_cnt == 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_led = r_led;

endmodule

// File: tb/tb_gp_regarb.sv
// Directed bench for gp_regarb: scoreboard of expected B/R responses plus a small register-bank model.
module tb_gp_regarb;

    localparam logic [7:0]  LED_RST = 8'h3C;
    localparam logic [31:0] SCR_RST = 32'h1234_5678;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef struct {
        logic [11:0] id;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] awid[2];  logic [31:0] awaddr[2]; logic [3:0] awlen[2]; logic awvalid[2]; logic awready[2];
    logic [31:0] wdata[2]; logic [3:0]  wstrb[2];  logic wvalid[2]; logic wready[2];
    logic [11:0] bid[2];   logic [1:0]  bresp[2];  logic bvalid[2]; logic bready[2];
    logic [11:0] arid[2];  logic [31:0] araddr[2]; logic [3:0] arlen[2]; logic arvalid[2]; logic arready[2];
    logic [11:0] rid[2];   logic [31:0] rdata[2];  logic [1:0] rresp[2]; logic rlast[2]; logic rvalid[2]; logic rready[2];
    logic [7:0]  led;
    logic [131:0] outs;

    assign outs = {awready[0], wready[0], bid[0], bresp[0], bvalid[0], arready[0], rid[0], rdata[0], rresp[0], rlast[0], rvalid[0],
                   awready[1], wready[1], bid[1], bresp[1], bvalid[1], arready[1], rid[1], rdata[1], rresp[1], rlast[1], rvalid[1]};

    gp_regarb #(.LED_RST(LED_RST), .SCRATCH_RST(SCR_RST)) dut (
        .i_clk0(clk), .i_rst(rst),
        .i_M_AXI_GP0_AWID(awid[0]), .i_M_AXI_GP0_AWADDR(awaddr[0]), .i_M_AXI_GP0_AWLEN(awlen[0]),
        .i_M_AXI_GP0_AWVALID(awvalid[0]), .o_M_AXI_GP0_AWREADY(awready[0]),
        .i_M_AXI_GP0_WDATA(wdata[0]), .i_M_AXI_GP0_WSTRB(wstrb[0]), .i_M_AXI_GP0_WVALID(wvalid[0]),
        .o_M_AXI_GP0_WREADY(wready[0]), .o_M_AXI_GP0_BID(bid[0]), .o_M_AXI_GP0_BRESP(bresp[0]),
        .o_M_AXI_GP0_BVALID(bvalid[0]), .i_M_AXI_GP0_BREADY(bready[0]),
        .i_M_AXI_GP0_ARID(arid[0]), .i_M_AXI_GP0_ARADDR(araddr[0]), .i_M_AXI_GP0_ARLEN(arlen[0]),
        .i_M_AXI_GP0_ARVALID(arvalid[0]), .o_M_AXI_GP0_ARREADY(arready[0]),
        .o_M_AXI_GP0_RID(rid[0]), .o_M_AXI_GP0_RDATA(rdata[0]), .o_M_AXI_GP0_RRESP(rresp[0]),
        .o_M_AXI_GP0_RLAST(rlast[0]), .o_M_AXI_GP0_RVALID(rvalid[0]), .i_M_AXI_GP0_RREADY(rready[0]),
        .i_M_AXI_GP1_AWID(awid[1]), .i_M_AXI_GP1_AWADDR(awaddr[1]), .i_M_AXI_GP1_AWLEN(awlen[1]),
        .i_M_AXI_GP1_AWVALID(awvalid[1]), .o_M_AXI_GP1_AWREADY(awready[1]),
        .i_M_AXI_GP1_WDATA(wdata[1]), .i_M_AXI_GP1_WSTRB(wstrb[1]), .i_M_AXI_GP1_WVALID(wvalid[1]),
        .o_M_AXI_GP1_WREADY(wready[1]), .o_M_AXI_GP1_BID(bid[1]), .o_M_AXI_GP1_BRESP(bresp[1]),
        .o_M_AXI_GP1_BVALID(bvalid[1]), .i_M_AXI_GP1_BREADY(bready[1]),
        .i_M_AXI_GP1_ARID(arid[1]), .i_M_AXI_GP1_ARADDR(araddr[1]), .i_M_AXI_GP1_ARLEN(arlen[1]),
        .i_M_AXI_GP1_ARVALID(arvalid[1]), .o_M_AXI_GP1_ARREADY(arready[1]),
        .o_M_AXI_GP1_RID(rid[1]), .o_M_AXI_GP1_RDATA(rdata[1]), .o_M_AXI_GP1_RRESP(rresp[1]),
        .o_M_AXI_GP1_RLAST(rlast[1]), .o_M_AXI_GP1_RVALID(rvalid[1]), .i_M_AXI_GP1_RREADY(rready[1]),
        .o_led(led)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t sb[$];

    logic [7:0]  m_led;
    logic [31:0] m_scratch;
    logic [15:0] m_g0, m_g1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic smp();  @(negedge clk);     endtask

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which, input int p);
        case (which)
            0:       return awready[p];
            1:       return wready[p];
            2:       return bvalid[p];
            3:       return arready[p];
            default: return rvalid[p];
        endcase
    endfunction

    task automatic wait_hi(input int which, input int p, input string tag, inout int waits);
        int n;
        n = 0;
        smp();
        while (!sig(which, p) && n < 40) begin
            tick();
            smp();
            n++;
        end
        chk(tag, 132'(sig(which, p)), 132'd1);
        waits += n;
    endtask

    function automatic logic [1:0] exp_resp(input bit wr, input logic [31:0] a, input logic [3:0] l);
        if (a[31:4] != 28'h0) return DECERR;
        if (l != 4'd0) return SLVERR;
        if (wr && a[3]) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [31:0] model_rd(input int p, input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {24'h0, m_led};
            2'd1:    return m_scratch;
            2'd3:    return (p == 0) ? {m_g1, m_g0 + 16'd1} : {m_g1 + 16'd1, m_g0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            awid[p] = '0; awaddr[p] = '0; awlen[p] = '0; awvalid[p] = 1'b0;
            wdata[p] = '0; wstrb[p] = '0; wvalid[p] = 1'b0; bready[p] = 1'b0;
            arid[p] = '0; araddr[p] = '0; arlen[p] = '0; arvalid[p] = 1'b0; rready[p] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_led = LED_RST; m_scratch = SCR_RST; m_g0 = 16'h0; m_g1 = 16'h0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_write(input int p, input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] data, input logic [3:0] strb, output int waits, output logic [7:0] led_b);
        exp_t e;
        logic [1:0] r;
        r = exp_resp(1'b1, addr, len);
        e.id = id; e.resp = r; e.data = 32'h0; e.last = 1'b0;
        sb.push_back(e);
        waits = 0;
        awid[p] = id; awaddr[p] = addr; awlen[p] = len; awvalid[p] = 1'b1;
        wait_hi(0, p, "awready", waits);
        if (p == 0) m_g0++; else m_g1++;
        tick();
        awvalid[p] = 1'b0; wdata[p] = data; wstrb[p] = strb; wvalid[p] = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            wait_hi(1, p, "wready", waits);
            tick();
        end
        wvalid[p] = 1'b0; bready[p] = 1'b1;
        wait_hi(2, p, "bvalid", waits);
        led_b = led;
        e = sb.pop_front();
        chk("bid", 132'(bid[p]), 132'(e.id));
        chk("bresp", 132'(bresp[p]), 132'(e.resp));
        tick();
        bready[p] = 1'b0;
        if (r == OKAY) begin
            if (!addr[2]) begin
                if (strb[0]) m_led = data[7:0];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input int p, input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input bit chk_data, output logic [31:0] got, output int waits, output int gcyc);
        exp_t e;
        logic [1:0] r;
        logic [31:0] d;
        r = exp_resp(1'b0, addr, len);
        d = (r == OKAY) ? model_rd(p, addr) : 32'h0;
        for (int b = 0; b <= int'(len); b++) begin
            e.id = id; e.resp = r; e.data = d; e.last = (b == int'(len));
            sb.push_back(e);
        end
        waits = 0;
        got = 32'h0;
        arid[p] = id; araddr[p] = addr; arlen[p] = len; arvalid[p] = 1'b1;
        wait_hi(3, p, "arready", waits);
        gcyc = cyc;
        if (p == 0) m_g0++; else m_g1++;
        tick();
        arvalid[p] = 1'b0; rready[p] = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            wait_hi(4, p, "rvalid", waits);
            e = sb.pop_front();
            chk("rid", 132'(rid[p]), 132'(e.id));
            chk("rresp", 132'(rresp[p]), 132'(e.resp));
            chk("rlast", 132'(rlast[p]), 132'(e.last));
            if (chk_data) chk("rdata", 132'(rdata[p]), 132'(e.data));
            got = rdata[p];
            tick();
        end
        rready[p] = 1'b0;
    endtask

    initial begin
        int w, c1, c2, k;
        logic [7:0]  lb;
        logic [31:0] got, d1, d2;
        int rem[2];
        int order[4];
        bit hs[2];
        exp_t e;

        clear_inputs();
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        smp();
        chk("rst_outs", outs, '0);
        chk("rst_led", 132'(led), 132'(LED_RST));
        tick();
        rst = 1'b0;
        smp();
        chk("post_rst_outs", outs, '0);
        tick();

        // Single write to LED: AW cycle 0, W cycle 1, B and LED cycle 2
        do_write(0, 12'h005, 32'h0, 4'd0, 32'h0000_00A5, 4'hF, w, lb);
        chk("wr_latency", 132'(w), 132'd0);
        chk("led_at_b", 132'(lb), 132'h0A5);
        chk("o_led", 132'(led), 132'(m_led));

        // Both ports request writes at once, two each: grants must alternate
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            awid[p] = 12'h10 + 12'(p); awaddr[p] = 32'h4; awlen[p] = 4'd0; awvalid[p] = 1'b1;
            wdata[p] = 32'hDEAD_BEEF; wstrb[p] = 4'hF; wvalid[p] = 1'b1; bready[p] = 1'b1;
            rem[p] = 2;
        end
        for (int i = 0; i < 4; i++) order[i] = -1;
        k = 0;
        for (int n = 0; n < 40 && k < 4; n++) begin
            smp();
            for (int p = 0; p < 2; p++) begin
                hs[p] = awready[p];
                if (awready[p] && k < 4) begin order[k] = p; k++; end
            end
            tick();
            for (int p = 0; p < 2; p++)
                if (hs[p]) begin
                    rem[p]--;
                    if (rem[p] == 0) awvalid[p] = 1'b0;
                end
        end
        repeat (4) tick();
        clear_inputs();
        m_g0 += 16'd2; m_g1 += 16'd2; m_scratch = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) chk($sformatf("arb_order%0d", i), 132'(order[i]), 132'(i % 2));
        do_read(0, 12'h041, 32'hC, 4'd0, 1'b1, got, w, c1);
        chk("grants_val", 132'(got), 132'h0002_0003);
        chk("rd_latency", 132'(w), 132'd0);

        // Error reads on GP1
        do_read(1, 12'h0A1, 32'h8, 4'd3, 1'b1, got, w, c1);
        do_read(1, 12'h0A2, 32'h20, 4'd0, 1'b1, got, w, c1);

        // Byte-masked SCRATCH write, then COUNT write must be rejected
        reset_dut();
        do_write(0, 12'h011, 32'h4, 4'd0, 32'hFFFF_FFFF, 4'h2, w, lb);
        do_read(0, 12'h012, 32'h4, 4'd0, 1'b1, got, w, c1);
        chk("scratch_val", 132'(got), 132'h1234_FF78);
        do_read(0, 12'h013, 32'h8, 4'd0, 1'b0, d1, w, c1);
        do_write(0, 12'h014, 32'h8, 4'd0, 32'h0, 4'hF, w, lb);
        do_read(0, 12'h015, 32'h8, 4'd0, 1'b0, d2, w, c2);
        chk("count_delta", 132'(d2 - d1), 132'(c2 - c1));
        do_write(1, 12'h016, 32'hC, 4'd0, 32'h0, 4'hF, w, lb);
        do_write(0, 12'h017, 32'h0, 4'd1, 32'hFF, 4'hF, w, lb);
        chk("led_after_len_err", 132'(led), 132'(m_led));

        // B stall: held response stays stable, GP1 read waits for IDLE
        w = 0;
        awid[0] = 12'h007; awaddr[0] = 32'h0; awlen[0] = 4'd0; awvalid[0] = 1'b1;
        wait_hi(0, 0, "stall_awready", w);
        m_g0++;
        tick();
        awvalid[0] = 1'b0; wdata[0] = 32'h5A; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
        wait_hi(1, 0, "stall_wready", w);
        tick();
        wvalid[0] = 1'b0; bready[0] = 1'b0; m_led = 8'h5A;
        arid[1] = 12'h033; araddr[1] = 32'h0; arlen[1] = 4'd0; arvalid[1] = 1'b1;
        e.id = 12'h033; e.resp = OKAY; e.data = model_rd(1, 32'h0); e.last = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            smp();
            chk($sformatf("b_hold%0d", i), 132'({bvalid[0], bid[0], bresp[0], arready[1]}), 132'({1'b1, 12'h007, OKAY, 1'b0}));
            tick();
        end
        bready[0] = 1'b1;
        smp();
        chk("b_final", 132'({bvalid[0], arready[1]}), 132'(2'b10));
        tick();
        bready[0] = 1'b0;
        smp();
        chk("ar_after_b", 132'(arready[1]), 132'd1);
        m_g1++;
        tick();
        arvalid[1] = 1'b0; rready[1] = 1'b1;
        smp();
        e = sb.pop_front();
        chk("r_after_b", 132'({rvalid[1], rid[1], rresp[1], rdata[1], rlast[1]}), 132'({1'b1, e.id, e.resp, e.data, e.last}));
        tick();
        rready[1] = 1'b0;

        // Reset during WDATA, with a W beat offered in the reset cycle
        w = 0;
        awid[0] = 12'h009; awaddr[0] = 32'h0; awlen[0] = 4'd0; awvalid[0] = 1'b1;
        wait_hi(0, 0, "mid_awready", w);
        tick();
        awvalid[0] = 1'b0;
        rst = 1'b1; wvalid[0] = 1'b1; wdata[0] = 32'hFF; wstrb[0] = 4'hF; bready[0] = 1'b1;
        tick();
        rst = 1'b0; wvalid[0] = 1'b0;
        model_reset();
        smp();
        chk("mid_rst_outs", outs, '0);
        chk("mid_rst_led", 132'(led), 132'(LED_RST));
        for (int i = 0; i < 4; i++) begin
            tick();
            smp();
            chk($sformatf("no_b%0d", i), 132'({bvalid[0], bvalid[1], led}), 132'({2'b00, LED_RST}));
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gp_regarb.md
Name: gp_regarb

Overview:
Two-port AXI3 slave that arbitrates single transactions from the PS7 GP0 and GP1 master ports onto one shared 4-word register bank. The bank holds the LED register, a scratch register, a free-running cycle counter and per-port grant counters. It replaces per-port always-ready slaves with fully sequenced AW/W/B and AR/R handshakes and correct ID reflection. Sits in pl_top between the PS7 GP ports and o_led.

Parameters:
LED_RST, 8'h00, reset value of LED register bits [7:0]
SCRATCH_RST, 32'h0000_0000, reset value of SCRATCH register

Ports:
i_clk0  in  1  clock; all logic single clock domain
i_rst  in  1  reset, synchronous, active-high
i_M_AXI_GPn_AWID  in  12  write ID, n=0,1 (one port per n; same for every line below)
i_M_AXI_GPn_AWADDR  in  32  write byte address
i_M_AXI_GPn_AWLEN  in  4  write burst length-1
i_M_AXI_GPn_AWVALID  in  1  write address valid
o_M_AXI_GPn_AWREADY  out  1  write address accepted
i_M_AXI_GPn_WDATA  in  32  write data
i_M_AXI_GPn_WSTRB  in  4  byte enables
i_M_AXI_GPn_WVALID  in  1  write data valid
o_M_AXI_GPn_WREADY  out  1  write data accepted
o_M_AXI_GPn_BID  out  12  reflected AWID
o_M_AXI_GPn_BRESP  out  2  write response
o_M_AXI_GPn_BVALID  out  1  write response valid
i_M_AXI_GPn_BREADY  in  1  write response accepted
i_M_AXI_GPn_ARID  in  12  read ID
i_M_AXI_GPn_ARADDR  in  32  read byte address
i_M_AXI_GPn_ARLEN  in  4  read burst length-1
i_M_AXI_GPn_ARVALID  in  1  read address valid
o_M_AXI_GPn_ARREADY  out  1  read address accepted
o_M_AXI_GPn_RID  out  12  reflected ARID
o_M_AXI_GPn_RDATA  out  32  read data
o_M_AXI_GPn_RRESP  out  2  read response
o_M_AXI_GPn_RLAST  out  1  last read beat
o_M_AXI_GPn_RVALID  out  1  read data valid
i_M_AXI_GPn_RREADY  in  1  read data accepted
o_led  out  8  LED register bits [7:0]

Behaviour:
- Register map, word index = ADDR[3:2]:
  - 0x0 LED: RW, bits [31:8] read 0.
  - 0x4 SCRATCH: RW.
  - 0x8 COUNT: RO, +1 every cycle, wraps at 2^32.
  - 0xC GRANTS: RO, [15:0] GP0 grant count, [31:16] GP1 grant count; each 16-bit, wraps.
- Response codes:
  - ADDR[31:4] != 0 -> DECERR, no effect.
  - Write to COUNT or GRANTS -> SLVERR, no effect.
  - AxLEN != 0 -> SLVERR, no register effect. DECERR takes precedence over SLVERR.
  - Otherwise OKAY. WSTRB masks bytes on RW registers.
- Requesters in ring order GP0-W, GP0-R, GP1-W, GP1-R.
  - Round-robin: the requester after the last winner has highest priority.
  - After reset the pointer gives GP0-W highest priority.
  - Exactly one transaction in flight across both ports.
- FSM states IDLE, WDATA, WRESP, RDATA:
  - IDLE: winner's AxREADY=1 combinationally in the same cycle as its AxVALID. Capture port, ID, addr, len, beat counter=len. Increment the winner port's GRANTS field. Go to WDATA or RDATA.
  - WDATA: WREADY=1 on the granted port only. Each W handshake decrements the counter. Write commits on the beat where counter==0 (WLAST ignored), then go to WRESP.
  - WRESP: BVALID=1, BID=captured ID. BVALID/BRESP/BID held until BREADY, then IDLE.
  - RDATA: RVALID=1, RID=captured ID. RDATA is the register value sampled at the grant cycle; 0 on any error. RLAST=1 when counter==0. Each RREADY handshake decrements the counter; RREADY with RLAST -> IDLE. All beats of an errored burst carry the same RRESP.
- Non-granted port: all READY/VALID=0, ID/DATA/RESP/LAST=0.
- Latency:
  - Single write: AW cycle 0, W at cycle 1 earliest, BVALID and o_led update at cycle 2.
  - Single read: AR cycle 0, RVALID cycle 1.
  - Back-to-back grants: IDLE occupies 1 cycle between transactions.
- Simultaneous AW and AR on the same port are treated as separate requesters; the ring order decides.
- Reset:
  - All outputs 0; o_led=LED_RST; SCRATCH=SCRATCH_RST; COUNT, GRANTS 0; state IDLE; pointer at GP0-W.
  - Reset mid-transaction aborts it: no B/R issued, no partial write.

Test Plan:
- GP0 AW addr 0x0 id 0x5, W 0x0000_00A5 strb 0xF -> AWREADY cycle 0; BVALID cycle 2 with BID 0x5, BRESP OKAY; o_led=0xA5 at cycle 2.
- GP0 and GP1 AWVALID same cycle, repeated 4 times -> grants alternate GP0,GP1,GP0,GP1; read of 0xC returns 0x0002_0002 (+1 for the read itself on the reading port).
- GP1 AR addr 0x8 len 3 -> 4 beats, RRESP SLVERR, RDATA 0, RLAST only on beat 4. GP1 AR addr 0x20 -> DECERR.
- GP0 write 0xFFFF_FFFF to SCRATCH strb 0x2 after reset -> read returns 0x0000_FF00; write to COUNT -> SLVERR, COUNT unaffected.
- BREADY held low 10 cycles -> BVALID/BID stable; a GP1 ARVALID meanwhile sees ARREADY=0 until 1 cycle after B handshake.
- Assert i_rst while in WDATA -> next cycle all outputs 0, LED unchanged from LED_RST, no BVALID afterwards.
